// File: rtl/qmem_pkg.sv
// QMEM slave shared definitions.
// State encodings and default bus widths.
package qmem_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HI_SETUP  = 3'd1;
  localparam logic [2:0] S_HI_STROBE = 3'd2;
  localparam logic [2:0] S_LO_SETUP  = 3'd3;
  localparam logic [2:0] S_LO_STROBE = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam int QMEM_AW = 22;
  localparam int QMEM_SW = 4;
  localparam int QMEM_DW = 32;

endpackage

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter timing one SRAM strobe.
// done is high while the count sits at zero.
module sram_strobe_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  // count down from the loaded value and park at zero
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/qmem_sram16_ctrl.sv
// QMEM 32-bit slave over a 16-bit async SRAM, big-endian halves.
// QMEM_SRAM_HALF_SKIP_EN: skip halves with no byte selected.
module qmem_sram16_ctrl
  import qmem_pkg::*;
#(
  parameter int QAW = QMEM_AW,
  parameter int QSW = QMEM_SW,
  parameter int QDW = QMEM_DW,
  parameter int SAW = 18,
  parameter int SDW = 16,
  parameter int WS  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic           we,
  input  logic [QAW-1:0] adr,
  input  logic [QSW-1:0] sel,
  input  logic [QDW-1:0] dat_w,
  output logic [QDW-1:0] dat_r,
  output logic           ack,
  output logic           err,
  output logic [SAW-1:0] sram_adr,
  output logic           sram_ce_n,
  output logic           sram_oe_n,
  output logic           sram_we_n,
  output logic           sram_ub_n,
  output logic           sram_lb_n,
  output logic [SDW-1:0] sram_dat_w,
  input  logic [SDW-1:0] sram_dat_r,
  output logic           sram_dat_oe
);

  localparam int CW = $clog2(WS);

  logic [2:0] st;
  logic [2:0] nxt;
  logic       ok;
  logic       hi_en;
  logic       lo_en;
  logic       setup;
  logic       strobe;
  logic       load;
  logic       done;

  assign ok = ((adr >> (SAW + 1)) == '0);

`ifdef QMEM_SRAM_HALF_SKIP_EN
  assign hi_en = sel[3] | sel[2];
  assign lo_en = sel[1] | sel[0];
`else
  assign hi_en = 1'b1;
  assign lo_en = 1'b1;
`endif

  assign setup  = (st == S_HI_SETUP) || (st == S_LO_SETUP);
  assign strobe = (st == S_HI_STROBE) || (st == S_LO_STROBE);
  assign load   = setup;

  sram_strobe_timer #(
    .CW(CW)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(CW'(WS - 1)),
    .done    (done)
  );

  // next-state decode of the access sequence
  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE: begin
        if (cs) begin
          if (!ok)
            nxt = S_ERR;
          else if (hi_en)
            nxt = S_HI_SETUP;
          else if (lo_en)
            nxt = S_LO_SETUP;
          else
            nxt = S_ACK;
        end
      end
      S_HI_SETUP:  nxt = S_HI_STROBE;
      S_HI_STROBE: if (done) nxt = lo_en ? S_LO_SETUP : S_ACK;
      S_LO_SETUP:  nxt = S_LO_STROBE;
      S_LO_STROBE: if (done) nxt = S_ACK;
      default:     nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      st <= S_IDLE;
    else
      st <= nxt;
  end

  // SRAM address, byte enables and write data set up on entry to SETUP
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_adr   <= '0;
      sram_dat_w <= '0;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else if (nxt == S_HI_SETUP) begin
      sram_adr  <= {adr[SAW:2], 1'b0};
      sram_ub_n <= ~sel[3];
      sram_lb_n <= ~sel[2];
      if (we)
        sram_dat_w <= dat_w[QDW-1:SDW];
    end else if (nxt == S_LO_SETUP) begin
      sram_adr  <= {adr[SAW:2], 1'b1};
      sram_ub_n <= ~sel[1];
      sram_lb_n <= ~sel[0];
      if (we)
        sram_dat_w <= dat_w[SDW-1:0];
    end else if (!setup && !strobe) begin
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end
  end

  // capture read halves at the edge ending the last strobe cycle
  always_ff @(posedge clk) begin
    if (rst)
      dat_r <= '0;
    else if (strobe && done && !we) begin
      if (st == S_HI_STROBE)
        dat_r[QDW-1:SDW] <= sram_dat_r;
      else
        dat_r[SDW-1:0] <= sram_dat_r;
    end
  end

  assign sram_ce_n   = !(setup || strobe);
  assign sram_oe_n   = !(strobe && !we);
  assign sram_we_n   = !(strobe && we && !done);
  assign sram_dat_oe = we && (setup || strobe);
  assign ack         = (st == S_ACK) || (st == S_ERR);
  assign err         = (st == S_ERR);

endmodule

// File: tb/tb_qmem_sram16_ctrl.sv
// Directed self-checking bench for qmem_sram16_ctrl.
// Includes a 16-bit SRAM model with byte enables.
module tb_qmem_sram16_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [21:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic [17:0] sram_adr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic [15:0] sram_dat_w;
  logic [15:0] sram_dat_r;
  logic        sram_dat_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qmem_sram16_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .we         (we),
    .adr        (adr),
    .sel        (sel),
    .dat_w      (dat_w),
    .dat_r      (dat_r),
    .ack        (ack),
    .err        (err),
    .sram_adr   (sram_adr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_dat_w (sram_dat_w),
    .sram_dat_r (sram_dat_r),
    .sram_dat_oe(sram_dat_oe)
  );

  // SRAM model
  logic [15:0] mem [0:255];

  assign sram_dat_r = (!sram_ce_n && !sram_oe_n) ?
                      mem[sram_adr[7:0]] : 16'hFFFF;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_adr[7:0]][15:8] <= sram_dat_w[15:8];
      if (!sram_lb_n) mem[sram_adr[7:0]][7:0]  <= sram_dat_w[7:0];
    end
  end

  // bus monitor
  int          oe_cnt  = 0;
  int          ce_cnt  = 0;
  int          bad_cnt = 0;
  logic [17:0] wq_adr[$];
  logic [15:0] wq_dat[$];
  logic [1:0]  wq_be[$];
  logic [17:0] p_adr;
  logic        p_ub;
  logic        p_lb;

  always @(negedge clk) begin
    if (!sram_oe_n) oe_cnt++;
    if (!sram_ce_n) ce_cnt++;
    if (!sram_we_n) begin
      wq_adr.push_back(sram_adr);
      wq_dat.push_back(sram_dat_w);
      wq_be.push_back({sram_ub_n, sram_lb_n});
      if (!sram_dat_oe) bad_cnt++;
    end
    if ((!sram_oe_n || !sram_we_n) &&
        (sram_adr != p_adr || sram_ub_n != p_ub ||
         sram_lb_n != p_lb))
      bad_cnt++;
    p_adr = sram_adr;
    p_ub  = sram_ub_n;
    p_lb  = sram_lb_n;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic req(input logic        we_i,
                     input logic [21:0] adr_i,
                     input logic [3:0]  sel_i,
                     input logic [31:0] dat_i,
                     output int          lat,
                     output logic [31:0] rd,
                     output logic        re);
    @(posedge clk);
    #1;
    cs    = 1'b1;
    we    = we_i;
    adr   = adr_i;
    sel   = sel_i;
    dat_w = dat_i;
    wait_ack(lat);
    rd = dat_r;
    re = err;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  int          lat;
  int          w0;
  int          o0;
  int          c0;
  logic [31:0] rd;
  logic        re;

  initial begin
    rst   = 1'b1;
    cs    = 1'b0;
    we    = 1'b0;
    adr   = '0;
    sel   = '0;
    dat_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat_r", dat_r, 32'd0);
    chk("rst_strb",
        {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
        32'h1F);
    chk("rst_oe", {31'd0, sram_dat_oe}, 32'd0);
    chk("rst_adr", {14'd0, sram_adr}, 32'd0);
    chk("rst_sdw", {16'd0, sram_dat_w}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // full word write
    w0 = wq_adr.size();
    o0 = oe_cnt;
    req(1'b1, 22'h000010, 4'hF, 32'h12345678, lat, rd, re);
    chk("wr_lat", lat, 32'd7);
    chk("wr_err", {31'd0, re}, 32'd0);
    chk("wr_nwe", wq_adr.size() - w0, 32'd2);
    chk("wr_a0", {14'd0, wq_adr[w0]}, 32'h8);
    chk("wr_d0", {16'd0, wq_dat[w0]}, 32'h1234);
    chk("wr_b0", {30'd0, wq_be[w0]}, 32'd0);
    chk("wr_a1", {14'd0, wq_adr[w0+1]}, 32'h9);
    chk("wr_d1", {16'd0, wq_dat[w0+1]}, 32'h5678);
    chk("wr_noe", oe_cnt - o0, 32'd0);

    // read back
    w0 = wq_adr.size();
    o0 = oe_cnt;
    req(1'b0, 22'h000010, 4'hF, 32'h0, lat, rd, re);
    chk("rd_lat", lat, 32'd7);
    chk("rd_dat", rd, 32'h12345678);
    chk("rd_noe", oe_cnt - o0, 32'd4);
    chk("rd_nwe", wq_adr.size() - w0, 32'd0);

    // single-byte write in the upper half
    w0 = wq_adr.size();
    req(1'b1, 22'h000010, 4'b0100, 32'hAABBCCDD, lat, rd, re);
    chk("bw_a0", {14'd0, wq_adr[w0]}, 32'h8);
    chk("bw_b0", {30'd0, wq_be[w0]}, 32'h2);
    chk("bw_d0", {16'd0, wq_dat[w0]}, 32'hAABB);
`ifdef QMEM_SRAM_HALF_SKIP_EN
    chk("bw_lat", lat, 32'd4);
    chk("bw_nwe", wq_adr.size() - w0, 32'd1);
`else
    chk("bw_lat", lat, 32'd7);
    chk("bw_nwe", wq_adr.size() - w0, 32'd2);
    chk("bw_a1", {14'd0, wq_adr[w0+1]}, 32'h9);
    chk("bw_b1", {30'd0, wq_be[w0+1]}, 32'h3);
`endif
    req(1'b0, 22'h000010, 4'hF, 32'h0, lat, rd, re);
    chk("bw_rd_lat", lat, 32'd7);
    chk("bw_rd", rd, 32'h12BB5678);

    // out-of-range address
    c0 = ce_cnt;
    req(1'b0, 22'h080000, 4'hF, 32'h0, lat, rd, re);
    chk("er_lat", lat, 32'd1);
    chk("er_err", {31'd0, re}, 32'd1);
    chk("er_ce", ce_cnt - c0, 32'd0);

    // reset as HI_STROBE begins, then back-to-back reads
    @(posedge clk);
    #1;
    cs  = 1'b1;
    we  = 1'b0;
    adr = 22'h000010;
    sel = 4'hF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ra_strb",
        {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
        32'h1F);
    chk("ra_ack", {31'd0, ack}, 32'd0);
    chk("ra_dat_r", dat_r, 32'd0);
    chk("ra_adr", {14'd0, sram_adr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ack(lat);
    chk("ra_lat", lat, 32'd7);
    chk("ra_rd", dat_r, 32'h12BB5678);
    wait_ack(lat);
    chk("b2b_gap", lat + 1, 32'd8);
    chk("b2b_rd", dat_r, 32'h12BB5678);
    @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (3) @(posedge clk);

    chk("stable", bad_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qmem_sram16_ctrl.md
# qmem_sram16_ctrl

Single-clock QMEM slave that serves 32-bit QMEM requests from a 16-bit asynchronous SRAM on the de0_nano/DE1-class boards. It sits on the slave side of the QMEM fabric, behind the async bridge, in the SRAM clock domain. Each word access is split into two SRAM half-word cycles with a programmable strobe length. Out-of-range addresses are rejected with `err`.

## Interface
Parameters:
- `QAW`, 22: QMEM byte-address width.
- `QSW`, 4: QMEM byte-select width.
- `QDW`, 32: QMEM data width.
- `SAW`, 18: SRAM half-word address width. `QAW` must be at least `SAW+1`.
- `SDW`, 16: SRAM data width.
- `WS`, 2: strobe cycles per half-word access. Minimum 2.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cs` in 1: QMEM request.
- `we` in 1: write when 1.
- `adr` in QAW: byte address.
- `sel` in QSW: byte selects.
- `dat_w` in QDW: write data.
- `dat_r` out QDW: read data.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: error, coincident with `ack`.
- `sram_adr` out SAW: SRAM half-word address.
- `sram_ce_n` out 1: chip enable, active-low.
- `sram_oe_n` out 1: output enable, active-low.
- `sram_we_n` out 1: write enable, active-low.
- `sram_ub_n` out 1: upper-byte enable, active-low.
- `sram_lb_n` out 1: lower-byte enable, active-low.
- `sram_dat_w` out SDW: data driven to the SRAM.
- `sram_dat_r` in SDW: data from the SRAM pads.
- `sram_dat_oe` out 1: pad driver enable. The tristate buffer lives in the top level.

## Operation
- QMEM rules:
  - The master holds `cs`, `adr`, `we`, `sel` and `dat_w` stable until `ack`.
  - `ack` is a one-cycle pulse. `dat_r` is valid in the `ack` cycle and holds until the next `ack`.
- Address check: if `adr[QAW-1:SAW+1]` is nonzero, the controller goes IDLE→ERR, which pulses `ack` and `err` together. No SRAM strobe is issued.
- Big-endian split (68k order):
  - First half: `sram_adr={adr[SAW:2],1'b0}`, `dat[31:16]`, `sel[3:2]`.
  - Second half: `sram_adr={adr[SAW:2],1'b1}`, `dat[15:0]`, `sel[1:0]`.
- `ub_n`/`lb_n` are the inverted selects of the current half. `adr[1:0]` is ignored.
- States:
  - IDLE → (cs & ok) HI_SETUP, or (cs & !ok) ERR.
  - HI_SETUP → HI_STROBE.
  - HI_STROBE runs WS cycles → LO_SETUP.
  - LO_SETUP → LO_STROBE.
  - LO_STROBE runs WS cycles → ACK.
  - ACK → IDLE.
  - ERR → IDLE.
- SETUP: `ce_n`=0; address and byte enables valid; `oe_n`=`we_n`=1; for writes, `dat_oe`=1 and `sram_dat_w` is loaded.
- Read STROBE: `oe_n`=0 for all WS cycles. `sram_dat_r` is registered into the matching half of `dat_r` at the clock edge that ends the last strobe cycle.
- Write STROBE:
  - `we_n`=0 for strobe cycles 1..WS-1.
  - `we_n`=1 in the last strobe cycle, which is the data-hold cycle; `dat_oe` stays 1.
- A strobe counter counts WS-1 down to 0.
- `ce_n`=1 in IDLE, ACK and ERR.
- `cs` is sampled only in IDLE. If `cs` is still high in the cycle after `ack`, it is taken as a new request.

## Timing
- Reset values: `ack`=0, `err`=0, `dat_r`=0, `sram_ce_n`=`sram_oe_n`=`sram_we_n`=`sram_ub_n`=`sram_lb_n`=1, `sram_dat_oe`=0, `sram_adr`=0, `sram_dat_w`=0, state IDLE.
- Reset mid-access forces all outputs to their reset values at the reset edge. No `ack` is issued for the aborted request.
- `cs` first high at cycle 0 (in IDLE):
  - `ack` is high in cycle 3+2·WS (cycle 7 for WS=2).
  - The earliest next request is sampled in cycle 4+2·WS.
- Error path: `ack`/`err` high in cycle 1; the next request is sampled in cycle 2.
- Between SETUP and STROBE, the address and byte enables never change while `oe_n`=0 or `we_n`=0.

## Configuration
- `QMEM_SRAM_HALF_SKIP_EN`
  - Defined: a half whose two `sel` bits are both 0 skips its SETUP and STROBE states. Its `dat_r` half is left unchanged.
  - Defined: if `sel`=0, the controller goes IDLE→ACK directly (ack in cycle 1).
  - Defined, word latency: single-half access `ack` in cycle 2+WS.
  - Undefined: both halves are always accessed, with the byte enables deasserted for unselected bytes.

## Structure
- Package `qmem_pkg`:
  - State encoding constants (IDLE, HI_SETUP, HI_STROBE, LO_SETUP, LO_STROBE, ACK, ERR).
  - QMEM default widths.
- Sub-module `sram_strobe_timer`: loadable down-counter with a `done` flag, used for the WS strobe count. Everything else lives in the top module.

## Test plan
- Write `adr`=0x000010, `sel`=4'hF, `dat_w`=0x12345678, WS=2:
  - `sram_adr`=0x000008 with data 0x1234, then `sram_adr`=0x000009 with data 0x5678.
  - `we_n` low for 1 cycle per half; `ack` in cycle 7.
- Read back `adr`=0x000010 from an SRAM model:
  - `dat_r`=0x12345678 in the `ack` cycle.
  - `oe_n` low for 2 cycles per half; `we_n` stays 1.
- Write with `sel`=4'b0100, `dat_w`=0xAABBCCDD:
  - First half: `ub_n`=1, `lb_n`=0.
  - With `QMEM_SRAM_HALF_SKIP_EN`: only address 0x000008 is strobed; `ack` in cycle 4.
  - Without it: second half with `ub_n`=`lb_n`=1; `ack` in cycle 7.
- Request to `adr`=0x080000 (SAW=18):
  - `ack`=`err`=1 in cycle 1.
  - `ce_n` never goes low.
- `rst` asserted in the cycle HI_STROBE begins: next cycle all strobes are 1, `ack`=0, state IDLE; a new read then completes normally.
- Back-to-back reads with `cs` held high across `ack`: the second request starts in the cycle after `ack`, with the second `ack` exactly 8 cycles after the first.
